// File: rtl/addr_gen_pkg.sv
// -----------------------------------------------------------------------------
// addr_gen_pkg
// Shared types, default widths and helpers for the strided address generator.
//
// Contents:
//   addr_gen_state_e  : controller states (IDLE, RUN)
//   DEF_ADDR_W        : default address width
//   DEF_STRIDE_W      : default stride field width
//   DEF_REP_W         : default repeat-count width
//   stride_eff()      : maps a zero stride to 1 so the walk always advances
//
// Optional feature macro used by the generator: ADDR_GEN_ABORT_EN
// -----------------------------------------------------------------------------
package addr_gen_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } addr_gen_state_e;

    localparam int DEF_ADDR_W   = 14;
    localparam int DEF_STRIDE_W = 8;
    localparam int DEF_REP_W    = 4;

    // A zero stride would never reach the end of the range, so it is
    // promoted to 1. Operates on a 32-bit container; callers resize.
    function automatic logic [31:0] stride_eff(input logic [31:0] stride);
        return (stride == 32'd0) ? 32'd1 : stride;
    endfunction

endpackage

// File: rtl/addr_gen_step.sv
// -----------------------------------------------------------------------------
// addr_gen_step
// Combinational step unit: given the current address, works out whether the
// next strided address leaves the range and what the following address is.
//
// Ports:
//   i_addr       : current address                  [ADDR_W-1:0]
//   i_stride     : effective (non-zero) stride      [STRIDE_W-1:0]
//   i_start      : first address of the range       [ADDR_W-1:0]
//   i_end        : inclusive upper bound            [ADDR_W-1:0]
//   o_endOfPass  : current address is the last one of this pass
//   o_addrNext   : next address (start again when the pass ends)
// -----------------------------------------------------------------------------
module addr_gen_step #(
    parameter int ADDR_W   = 14,
    parameter int STRIDE_W = 8
) (
    input  logic [ADDR_W-1:0]   i_addr,
    input  logic [STRIDE_W-1:0] i_stride,
    input  logic [ADDR_W-1:0]   i_start,
    input  logic [ADDR_W-1:0]   i_end,
    output logic                o_endOfPass,
    output logic [ADDR_W-1:0]   o_addrNext
);

    logic [ADDR_W:0] w_nxt;

    // The sum is one bit wider than the address so a carry out of the top
    // of the address space compares as larger than any end bound, which
    // ends the pass instead of wrapping back to a low address. A start
    // above end also lands here, giving exactly one beat per pass.
    always_comb begin
        w_nxt       = {1'b0, i_addr} + (ADDR_W+1)'(i_stride);
        o_endOfPass = (w_nxt > {1'b0, i_end});
        o_addrNext  = o_endOfPass ? i_start : w_nxt[ADDR_W-1:0];
    end

endmodule

// File: rtl/dffre.sv
// -----------------------------------------------------------------------------
// dffre
// Team flop: D flip-flop with synchronous active-low reset and clock enable.
//
// Ports:
//   i_clk  : clock
//   i_rstn : synchronous reset, active-low, clears o_q to zero
//   i_en   : load enable
//   i_d    : data in  [W-1:0]
//   o_q    : data out [W-1:0]
// -----------------------------------------------------------------------------
module dffre #(
    parameter int W = 1
) (
    input  logic         i_clk,
    input  logic         i_rstn,
    input  logic         i_en,
    input  logic [W-1:0] i_d,
    output logic [W-1:0] o_q
);

    // Reset wins over enable so every instance comes up at zero.
    always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
            o_q <= '0;
        end else if (i_en) begin
            o_q <= i_d;
        end
    end

endmodule

// File: rtl/addr_gen_strided.sv
// -----------------------------------------------------------------------------
// addr_gen_strided
// Strided, repeating address generator placed between the command decoder
// and an SRAM/BRAM read port. A descriptor (start, end, stride, repeat) is
// taken over a valid/ready config port; addresses start, start+stride, ...
// up to end are streamed over a valid/ready output port, repeat+1 times.
//
// Ports:
//   clk        : system clock
//   rstn       : synchronous reset, active-low
//   cfg_valid  : descriptor offered
//   cfg_ready  : descriptor can be accepted (controller idle)
//   cfg_start  : first address                 [ADDR_W-1:0]
//   cfg_end    : inclusive upper bound         [ADDR_W-1:0]
//   cfg_stride : increment, 0 behaves as 1     [STRIDE_W-1:0]
//   cfg_repeat : extra passes over the range   [REP_W-1:0]
//   out_valid  : out_addr is valid
//   out_ready  : consumer accepts the beat
//   out_addr   : current address               [ADDR_W-1:0]
//   out_last   : final beat of the final pass
//   busy       : descriptor in progress
//   done       : one-cycle pulse after the final handshake
//   abort      : (ADDR_GEN_ABORT_EN only) abandon the running descriptor
//
// Build option: define ADDR_GEN_ABORT_EN to add the abort input.
// -----------------------------------------------------------------------------
module addr_gen_strided
    import addr_gen_pkg::*;
#(
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int STRIDE_W = DEF_STRIDE_W,
    parameter int REP_W    = DEF_REP_W
) (
    input  logic                clk,
    input  logic                rstn,
    input  logic                cfg_valid,
    output logic                cfg_ready,
    input  logic [ADDR_W-1:0]   cfg_start,
    input  logic [ADDR_W-1:0]   cfg_end,
    input  logic [STRIDE_W-1:0] cfg_stride,
    input  logic [REP_W-1:0]    cfg_repeat,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [ADDR_W-1:0]   out_addr,
    output logic                out_last,
    output logic                busy,
    output logic                done
`ifdef ADDR_GEN_ABORT_EN
    ,
    input  logic                abort
`endif
);

    addr_gen_state_e     w_state;
    addr_gen_state_e     w_stateNext;
    logic                r_stateBit;

    logic [ADDR_W-1:0]   r_start;
    logic [ADDR_W-1:0]   r_end;
    logic [STRIDE_W-1:0] r_stride;
    logic [REP_W-1:0]    r_repeat;
    logic [ADDR_W-1:0]   r_addr;
    logic [REP_W-1:0]    r_passCnt;
    logic                r_done;

    logic                w_cfgLoad;
    logic                w_addrEn;
    logic [ADDR_W-1:0]   w_addrNext;
    logic                w_passEn;
    logic [REP_W-1:0]    w_passNext;
    logic                w_doneNext;

    logic [STRIDE_W-1:0] w_strideEff;
    logic                w_endOfPass;
    logic [ADDR_W-1:0]   w_stepAddr;
    logic                w_lastPass;
    logic                w_fire;
    logic                w_abort;

    // ---------------------------------------------------------------------
    // State and descriptor registers, all built from the shared flop.
    // ---------------------------------------------------------------------
    dffre #(.W(1)) u_state (
        .i_clk  (clk),
        .i_rstn (rstn),
        .i_en   (1'b1),
        .i_d    (w_stateNext),
        .o_q    (r_stateBit)
    );

    assign w_state = addr_gen_state_e'(r_stateBit);

    dffre #(.W(ADDR_W)) u_start (
        .i_clk  (clk),
        .i_rstn (rstn),
        .i_en   (w_cfgLoad),
        .i_d    (cfg_start),
        .o_q    (r_start)
    );

    dffre #(.W(ADDR_W)) u_end (
        .i_clk  (clk),
        .i_rstn (rstn),
        .i_en   (w_cfgLoad),
        .i_d    (cfg_end),
        .o_q    (r_end)
    );

    dffre #(.W(STRIDE_W)) u_stride (
        .i_clk  (clk),
        .i_rstn (rstn),
        .i_en   (w_cfgLoad),
        .i_d    (cfg_stride),
        .o_q    (r_stride)
    );

    dffre #(.W(REP_W)) u_repeat (
        .i_clk  (clk),
        .i_rstn (rstn),
        .i_en   (w_cfgLoad),
        .i_d    (cfg_repeat),
        .o_q    (r_repeat)
    );

    dffre #(.W(ADDR_W)) u_addr (
        .i_clk  (clk),
        .i_rstn (rstn),
        .i_en   (w_addrEn),
        .i_d    (w_addrNext),
        .o_q    (r_addr)
    );

    dffre #(.W(REP_W)) u_passCnt (
        .i_clk  (clk),
        .i_rstn (rstn),
        .i_en   (w_passEn),
        .i_d    (w_passNext),
        .o_q    (r_passCnt)
    );

    dffre #(.W(1)) u_done (
        .i_clk  (clk),
        .i_rstn (rstn),
        .i_en   (1'b1),
        .i_d    (w_doneNext),
        .o_q    (r_done)
    );

    // ---------------------------------------------------------------------
    // Step datapath: effective stride and next-address decision.
    // ---------------------------------------------------------------------
    assign w_strideEff = STRIDE_W'(stride_eff(32'(r_stride)));

    addr_gen_step #(
        .ADDR_W   (ADDR_W),
        .STRIDE_W (STRIDE_W)
    ) u_step (
        .i_addr      (r_addr),
        .i_stride    (w_strideEff),
        .i_start     (r_start),
        .i_end       (r_end),
        .o_endOfPass (w_endOfPass),
        .o_addrNext  (w_stepAddr)
    );

    // Handshake and pass bookkeeping. Everything here is derived from
    // registers only, so out_addr/out_last cannot move during a stall.
    always_comb begin
        w_lastPass = (r_passCnt == r_repeat);
        w_fire     = (w_state == RUN) & out_ready;
`ifdef ADDR_GEN_ABORT_EN
        w_abort    = (w_state == RUN) & abort;
`else
        w_abort    = 1'b0;
`endif
    end

    // ---------------------------------------------------------------------
    // Next-state and register-update decode. IDLE only listens to the
    // config port; RUN only reacts to output handshakes (and abort).
    // ---------------------------------------------------------------------
    always_comb begin
        w_stateNext = w_state;
        w_cfgLoad   = 1'b0;
        w_addrEn    = 1'b0;
        w_addrNext  = r_addr;
        w_passEn    = 1'b0;
        w_passNext  = r_passCnt;
        w_doneNext  = 1'b0;

        unique case (w_state)
            IDLE: begin
                if (cfg_valid) begin
                    w_stateNext = RUN;
                    w_cfgLoad   = 1'b1;
                    w_addrEn    = 1'b1;
                    w_addrNext  = cfg_start;
                    w_passEn    = 1'b1;
                    w_passNext  = '0;
                end
            end
            RUN: begin
                if (w_fire) begin
                    if (!w_endOfPass) begin
                        w_addrEn   = 1'b1;
                        w_addrNext = w_stepAddr;
                    end else if (!w_lastPass) begin
                        w_addrEn   = 1'b1;
                        w_addrNext = w_stepAddr;
                        w_passEn   = 1'b1;
                        w_passNext = r_passCnt + REP_W'(1);
                    end else begin
                        w_stateNext = IDLE;
                        w_doneNext  = 1'b1;
                    end
                end
                // An abort still lets a coinciding beat count as sent;
                // it only stops anything after it.
                if (w_abort) begin
                    w_stateNext = IDLE;
                    w_doneNext  = 1'b1;
                end
            end
            default: begin
                w_stateNext = IDLE;
            end
        endcase
    end

    // ---------------------------------------------------------------------
    // Output decode.
    // ---------------------------------------------------------------------
    always_comb begin
        cfg_ready = (w_state == IDLE);
        busy      = (w_state == RUN);
        out_valid = (w_state == RUN);
        out_addr  = r_addr;
        out_last  = (w_state == RUN) & w_endOfPass & w_lastPass;
        done      = r_done;
    end

endmodule

// File: tb/tb_addr_gen_strided.sv
// -----------------------------------------------------------------------------
// tb_addr_gen_strided
// Directed, table-driven bench for addr_gen_strided. Full-throughput
// descriptors come from a vector table with hand-computed beat lists;
// stalls, back-to-back descriptors, reset mid-run and (with
// ADDR_GEN_ABORT_EN) abort are hand-written sequences.
// -----------------------------------------------------------------------------
module tb_addr_gen_strided;

    logic        clk;
    logic        rstn;
    logic        cfg_valid;
    logic        cfg_ready;
    logic [13:0] cfg_start;
    logic [13:0] cfg_end;
    logic [7:0]  cfg_stride;
    logic [3:0]  cfg_repeat;
    logic        out_valid;
    logic        out_ready;
    logic [13:0] out_addr;
    logic        out_last;
    logic        busy;
    logic        done;
`ifdef ADDR_GEN_ABORT_EN
    logic        abort;
`endif

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [13:0] startA;
        logic [13:0] endA;
        logic [7:0]  stride;
        logic [3:0]  rep;
        int          nBeats;
        int          base;
    } vec_t;

    vec_t vecs [6];
    int   expList [26];

    addr_gen_strided dut (
        .clk        (clk),
        .rstn       (rstn),
        .cfg_valid  (cfg_valid),
        .cfg_ready  (cfg_ready),
        .cfg_start  (cfg_start),
        .cfg_end    (cfg_end),
        .cfg_stride (cfg_stride),
        .cfg_repeat (cfg_repeat),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_addr   (out_addr),
        .out_last   (out_last),
        .busy       (busy),
        .done       (done)
`ifdef ADDR_GEN_ABORT_EN
        ,
        .abort      (abort)
`endif
    );

    // Free-running 100 MHz clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Advance one clock and settle just after the edge, where outputs are
    // sampled and the next inputs are driven.
    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [13:0] s, input logic [13:0] e,
                                 input logic [7:0] st, input logic [3:0] r,
                                 input logic v);
        cfg_start  = s;
        cfg_end    = e;
        cfg_stride = st;
        cfg_repeat = r;
        cfg_valid  = v;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    // Full-throughput run of one table entry, including the done pulse.
    task automatic runVector(input int v);
        applyStimulus(vecs[v].startA, vecs[v].endA, vecs[v].stride, vecs[v].rep, 1'b1);
        out_ready = 1'b1;
        tick();
        cfg_valid = 1'b0;
        for (int k = 0; k < vecs[v].nBeats; k++) begin
            checkOutput($sformatf("v%0d valid[%0d]", v, k), 32'(out_valid), 32'd1);
            checkOutput($sformatf("v%0d addr[%0d]", v, k), 32'(out_addr), 32'(expList[vecs[v].base + k]));
            checkOutput($sformatf("v%0d last[%0d]", v, k), 32'(out_last), 32'(k == vecs[v].nBeats - 1));
            if (k == 0) begin
                checkOutput($sformatf("v%0d cfg_ready busy", v), 32'(cfg_ready), 32'd0);
            end
            tick();
        end
        checkOutput($sformatf("v%0d done", v), 32'(done), 32'd1);
        checkOutput($sformatf("v%0d valid after", v), 32'(out_valid), 32'd0);
        checkOutput($sformatf("v%0d cfg_ready in done", v), 32'(cfg_ready), 32'd1);
        tick();
        checkOutput($sformatf("v%0d done one cycle", v), 32'(done), 32'd0);
    endtask

    initial begin
        int   beat;
        int   cyc;
        bit   pat [4];
        int   expA [4];

        vecs[0] = '{14'd10,     14'd20,     8'd3, 4'd0, 4,  0};
        vecs[1] = '{14'd0,      14'd3,      8'd1, 4'd2, 12, 4};
        vecs[2] = '{14'h3FFE,   14'h3FFF,   8'd4, 4'd0, 1,  16};
        vecs[3] = '{14'd9,      14'd5,      8'd2, 4'd1, 2,  17};
        vecs[4] = '{14'd7,      14'd7,      8'd5, 4'd0, 1,  19};
        vecs[5] = '{14'h100,    14'h110,    8'd8, 4'd1, 6,  20};
        expList = '{10, 13, 16, 19,
                    0, 1, 2, 3, 0, 1, 2, 3, 0, 1, 2, 3,
                    'h3FFE,
                    9, 9,
                    7,
                    'h100, 'h108, 'h110, 'h100, 'h108, 'h110};

        rstn      = 1'b0;
        out_ready = 1'b0;
`ifdef ADDR_GEN_ABORT_EN
        abort     = 1'b0;
`endif
        applyStimulus(14'd0, 14'd0, 8'd0, 4'd0, 1'b0);
        tick();
        tick();
        checkOutput("reset out_valid", 32'(out_valid), 32'd0);
        checkOutput("reset out_addr", 32'(out_addr), 32'd0);
        checkOutput("reset out_last", 32'(out_last), 32'd0);
        checkOutput("reset busy", 32'(busy), 32'd0);
        checkOutput("reset done", 32'(done), 32'd0);
        checkOutput("reset cfg_ready", 32'(cfg_ready), 32'd1);
        rstn = 1'b1;
        tick();

        for (int v = 0; v < 6; v++) begin
            runVector(v);
        end

        // Stride 0 walks by 1; out_ready pattern 1,0,0,1 stalls mid-run.
        pat  = '{1'b1, 1'b0, 1'b0, 1'b1};
        expA = '{5, 6, 7, 0};
        applyStimulus(14'd5, 14'd7, 8'd0, 4'd0, 1'b1);
        out_ready = 1'b0;
        tick();
        cfg_valid = 1'b0;
        beat = 0;
        cyc  = 0;
        while (beat < 3 && cyc < 40) begin
            out_ready = pat[cyc % 4];
            checkOutput($sformatf("stall valid c%0d", cyc), 32'(out_valid), 32'd1);
            checkOutput($sformatf("stall addr c%0d", cyc), 32'(out_addr), 32'(expA[beat]));
            checkOutput($sformatf("stall last c%0d", cyc), 32'(out_last), 32'(beat == 2));
            tick();
            if (out_ready) beat++;
            cyc++;
        end
        checkOutput("stall beats delivered", 32'(beat), 32'd3);
        checkOutput("stall done", 32'(done), 32'd1);
        checkOutput("stall valid after", 32'(out_valid), 32'd0);
        out_ready = 1'b1;
        tick();
        checkOutput("stall done one cycle", 32'(done), 32'd0);

        // Back-to-back: second descriptor held valid through the first run.
        expA = '{10, 13, 16, 19};
        applyStimulus(14'd10, 14'd20, 8'd3, 4'd0, 1'b1);
        tick();
        applyStimulus(14'd0, 14'd3, 8'd1, 4'd0, 1'b1);
        for (int k = 0; k < 4; k++) begin
            checkOutput($sformatf("b2b A addr[%0d]", k), 32'(out_addr), 32'(expA[k]));
            checkOutput($sformatf("b2b A cfg_ready[%0d]", k), 32'(cfg_ready), 32'd0);
            tick();
        end
        checkOutput("b2b A done", 32'(done), 32'd1);
        checkOutput("b2b A cfg_ready in done", 32'(cfg_ready), 32'd1);
        checkOutput("b2b A valid gap", 32'(out_valid), 32'd0);
        tick();
        cfg_valid = 1'b0;
        checkOutput("b2b B done low", 32'(done), 32'd0);
        for (int k = 0; k < 4; k++) begin
            checkOutput($sformatf("b2b B valid[%0d]", k), 32'(out_valid), 32'd1);
            checkOutput($sformatf("b2b B addr[%0d]", k), 32'(out_addr), 32'(k));
            checkOutput($sformatf("b2b B last[%0d]", k), 32'(out_last), 32'(k == 3));
            tick();
        end
        checkOutput("b2b B done", 32'(done), 32'd1);
        tick();

        // Reset while addr 13 is presented: descriptor dropped, no done.
        applyStimulus(14'd10, 14'd20, 8'd3, 4'd0, 1'b1);
        out_ready = 1'b1;
        tick();
        cfg_valid = 1'b0;
        checkOutput("rst-run addr 10", 32'(out_addr), 32'd10);
        tick();
        checkOutput("rst-run addr 13", 32'(out_addr), 32'd13);
        rstn = 1'b0;
        tick();
        checkOutput("rst-run out_valid", 32'(out_valid), 32'd0);
        checkOutput("rst-run busy", 32'(busy), 32'd0);
        checkOutput("rst-run cfg_ready", 32'(cfg_ready), 32'd1);
        checkOutput("rst-run done", 32'(done), 32'd0);
        checkOutput("rst-run out_addr", 32'(out_addr), 32'd0);
        rstn = 1'b1;
        tick();
        checkOutput("rst-run done later", 32'(done), 32'd0);
        checkOutput("rst-run valid later", 32'(out_valid), 32'd0);

`ifdef ADDR_GEN_ABORT_EN
        // Abort while addr 13 is presented: done pulse, no further beats.
        applyStimulus(14'd10, 14'd20, 8'd3, 4'd0, 1'b1);
        out_ready = 1'b1;
        tick();
        cfg_valid = 1'b0;
        tick();
        checkOutput("abort addr 13", 32'(out_addr), 32'd13);
        out_ready = 1'b0;
        abort     = 1'b1;
        tick();
        abort = 1'b0;
        checkOutput("abort done", 32'(done), 32'd1);
        checkOutput("abort valid", 32'(out_valid), 32'd0);
        checkOutput("abort cfg_ready", 32'(cfg_ready), 32'd1);
        tick();
        checkOutput("abort done one cycle", 32'(done), 32'd0);
        checkOutput("abort no more beats", 32'(out_valid), 32'd0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
